ntt_intt_processing_unit: RTL and testbench

// - Fully parallel, pipelined negacyclic NTT/INTT engine over Z_Q for one D-coefficient polynomial.
// - Forward: Cooley-Tukey; normal-order input; bit-reversed-order output.
// - Inverse: Gentleman-Sande; bit-reversed-order input; normal-order output, scaled by D^-1.
// - Sits between coefficient buffers and the polynomial-multiply datapath; accepts one polynomial per clock.

---
 rtl/ntt_pkg.sv | 74 +++++++
 rtl/ntt_butterfly.sv | 38 +++
 rtl/ntt_intt_processing_unit.sv | 112 +++++++++++
 tb/tb_ntt_intt_processing_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and modular-arithmetic helpers for the NTT/INTT engine.
// All helpers work on a fixed 32-bit coefficient container; callers narrow the results.
package ntt_pkg;

  localparam int unsigned CW = 32;
  typedef logic [CW-1:0]   coef_t;
  typedef logic [2*CW-1:0] wide_t;

  localparam int unsigned DEFAULT_N = 17;
  localparam int unsigned DEFAULT_D = 16;
  localparam int unsigned DEFAULT_Q = 65537;
  localparam coef_t       FERMAT_Q  = 32'd65537;

  function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Both operands are already in [0,q-1], so one conditional subtract suffices.
  function automatic coef_t mod_add(input coef_t x, input coef_t y, input coef_t q);
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[CW-1:0];
  endfunction

  function automatic coef_t mod_sub(input coef_t x, input coef_t y, input coef_t q);
    return (x >= y) ? x - y : x + q - y;
  endfunction

  function automatic coef_t mod_reduce(input coef_t x, input coef_t q);
    return x % q;
  endfunction

  function automatic coef_t mod_mul_generic(input coef_t x, input coef_t y, input coef_t q);
    wide_t p;
    p = wide_t'(x) * wide_t'(y);
    return coef_t'(p % wide_t'(q));
  endfunction

  // For q = 2^16+1 the product is at most 2^32, so p = hi*2^16 + lo with hi <= 2^16,
  // and 2^16 = -1 turns the reduction into lo - hi plus one correction.
  function automatic coef_t mod_mul(input coef_t x, input coef_t y, input coef_t q);
    wide_t p;
    wide_t r;
    if (q == FERMAT_Q) begin
      p = wide_t'(x) * wide_t'(y);
      r = (p & 64'hFFFF) + wide_t'(q) - (p >> 16);
      if (r >= wide_t'(q)) r = r - wide_t'(q);
      return coef_t'(r);
    end
    return mod_mul_generic(x, y, q);
  endfunction

  // Fermat inverse d^(q-2); evaluated only at elaboration.
  function automatic coef_t d_inverse(input coef_t d, input coef_t q);
    coef_t r;
    coef_t b;
    coef_t e;
    r = 1;
    b = d % q;
    e = q - 2;
    for (int i = 0; i < CW; i++) begin
      if (e[i]) r = mod_mul_generic(r, b, q);
      b = mod_mul_generic(b, b, q);
    end
    return r;
  endfunction

  localparam coef_t D_INV = d_inverse(coef_t'(DEFAULT_D), coef_t'(DEFAULT_Q));

endpackage

// File: rtl/ntt_butterfly.sv
// One combinational butterfly: Cooley-Tukey when inv=0, Gentleman-Sande when inv=1.
// A single modular multiplier is shared between the two forms.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int Q = DEFAULT_Q
) (
  input  logic [N-1:0] u,
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic         inv,
  output logic [N-1:0] y0,
  output logic [N-1:0] y1
);

  localparam coef_t QC = coef_t'(Q);

  coef_t uc;
  coef_t vc;
  coef_t wc;
  coef_t diff;
  coef_t mul_in;
  coef_t prod;

  assign uc = coef_t'(u);
  assign vc = coef_t'(v);
  assign wc = coef_t'(w);

  // CT multiplies v by w before the add/sub; GS multiplies the difference after it.
  assign diff   = mod_sub(uc, vc, QC);
  assign mul_in = inv ? diff : vc;
  assign prod   = mod_mul(mul_in, wc, QC);

  assign y0 = N'(inv ? mod_add(uc, vc, QC) : mod_add(uc, prod, QC));
  assign y1 = N'(inv ? prod : mod_sub(uc, prod, QC));

endmodule

// File: rtl/ntt_intt_processing_unit.sv
// Fully parallel pipelined negacyclic NTT/INTT: input register, log2(D) butterfly
// layers and an output/scale register; one polynomial per clock, latency log2(D)+2.
module ntt_intt_processing_unit
  import ntt_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int D = DEFAULT_D,
  parameter int Q = DEFAULT_Q
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D*N-1:0] a,
  input  logic           inv,
  input  logic [D*N-1:0] twiddle_factor,
  input  logic [D*N-1:0] inverse_twiddle_factor,
  output logic [D*N-1:0] an
);

  localparam int          L       = $clog2(D);
  localparam coef_t       QC      = coef_t'(Q);
  localparam logic [N-1:0] Q_N    = N'(Q);
  localparam coef_t       D_INV_L = (D == DEFAULT_D && Q == DEFAULT_Q) ? D_INV
                                                                       : d_inverse(coef_t'(D), QC);

  // Row 0 is the input register, rows 1..L the butterfly layer registers.
  logic [L:0][D-1:0][N-1:0] stage_d;
  logic [L:0][D-1:0][N-1:0] stage_q;
  logic [L:0]               inv_q;
  logic [D*N-1:0]           an_d;

  // Word 0 of each twiddle table is never addressed by any layer.
  logic unused_tw;
  assign unused_tw = ^{twiddle_factor[N-1:0], inverse_twiddle_factor[N-1:0]};

  for (genvar k = 0; k < D; k++) begin : g_s0
    logic [N-1:0] raw;
    assign raw = a[k*N +: N];
    if ((2 ** N) <= 2 * Q) begin : g_sub
      assign stage_d[0][k] = (raw >= Q_N) ? raw - Q_N : raw;
    end else begin : g_mod
      assign stage_d[0][k] = N'(mod_reduce(coef_t'(raw), QC));
    end
  end

  // Forward layer s pairs indices D/2^s apart; inverse layer s pairs them 2^(s-1)
  // apart. Each butterfly muxes its operands by the inv bit travelling with the data.
  for (genvar s = 1; s <= L; s++) begin : g_layer
    localparam int LEN_F = D >> s;
    localparam int M_F   = 1 << (s - 1);
    localparam int LEN_I = 1 << (s - 1);
    localparam int M_I   = D >> s;

    logic [N-1:0] y0 [D/2];
    logic [N-1:0] y1 [D/2];

    for (genvar b = 0; b < D / 2; b++) begin : g_bf
      localparam int JF = (b / LEN_F) * 2 * LEN_F + b % LEN_F;
      localparam int JI = (b / LEN_I) * 2 * LEN_I + b % LEN_I;
      localparam int WF = M_F + b / LEN_F;
      localparam int WI = M_I + b / LEN_I;

      logic [N-1:0] u;
      logic [N-1:0] v;
      logic [N-1:0] w;

      assign u = inv_q[s-1] ? stage_q[s-1][JI]         : stage_q[s-1][JF];
      assign v = inv_q[s-1] ? stage_q[s-1][JI + LEN_I] : stage_q[s-1][JF + LEN_F];
      assign w = inv_q[s-1] ? inverse_twiddle_factor[WI*N +: N] : twiddle_factor[WF*N +: N];

      ntt_butterfly #(.N(N), .Q(Q)) u_bf (
        .u   (u),
        .v   (v),
        .w   (w),
        .inv (inv_q[s-1]),
        .y0  (y0[b]),
        .y1  (y1[b])
      );
    end

    // Route each butterfly output back to the coefficient slot it overwrites.
    for (genvar k = 0; k < D; k++) begin : g_route
      localparam int BF = (k / (2 * LEN_F)) * LEN_F + k % LEN_F;
      localparam int BI = (k / (2 * LEN_I)) * LEN_I + k % LEN_I;
      localparam bit HF = ((k / LEN_F) % 2) == 1;
      localparam bit HI = ((k / LEN_I) % 2) == 1;

      assign stage_d[s][k] = inv_q[s-1] ? (HI ? y1[BI] : y0[BI])
                                        : (HF ? y1[BF] : y0[BF]);
    end
  end

  for (genvar k = 0; k < D; k++) begin : g_out
    logic [N-1:0] scaled;
    assign scaled = N'(mod_mul(coef_t'(stage_q[L][k]), D_INV_L, QC));
    assign an_d[k*N +: N] = inv_q[L] ? scaled : stage_q[L][k];
  end

  // NOTE: every pipeline row is reset (not just a valid bit) so that in-flight data
  // is discarded; all state uses non-blocking assignment so rows shift in lockstep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
      inv_q   <= '0;
      an      <= '0;
    end else begin
      stage_q <= stage_d;
      inv_q   <= {inv_q[L-1:0], inv};
      an      <= an_d;
    end
  end

endmodule

// File: tb/tb_ntt_intt_processing_unit.sv
// Self-checking bench: table vectors, reset sequences and a randomized round trip,
// all compared with a direct-evaluation negacyclic transform model.
module tb_ntt_intt_processing_unit;

  localparam int N       = 17;
  localparam int D       = 16;
  localparam int Q       = 65537;
  localparam int L       = 4;
  localparam int LAT     = 6;
  localparam longint unsigned D_INV_TB = 61441;

  typedef logic [D*N-1:0] vec_t;

  typedef struct {
    vec_t a;
    logic inv;
    vec_t exp;
  } vec_rec_t;

  logic clk;
  logic rst;
  logic inv;
  vec_t a;
  vec_t tf;
  vec_t itf;
  vec_t an;

  int checks;
  int failures;
  int cyc;

  longint unsigned psi_pow [2*D];

  vec_t  exp_q [$];
  int    due_q [$];
  string name_q[$];

  vec_rec_t tbl [8];

  ntt_intt_processing_unit #(.N(N), .D(D), .Q(Q)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .a                      (a),
    .inv                    (inv),
    .twiddle_factor         (tf),
    .inverse_twiddle_factor (itf),
    .an                     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int brv(input int k);
    int r;
    r = 0;
    for (int i = 0; i < L; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic vec_t fill(input int unsigned val);
    vec_t r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*N +: N] = val[N-1:0];
    return r;
  endfunction

  // Forward: slot o holds a(psi^(2*brv(o)+1)). Inverse: slot i holds A_brv(i), and
  // a_j = D^-1 * sum_i x_i * psi^-(2*brv(i)+1)*j.
  function automatic vec_t model(input vec_t x, input logic iv);
    longint unsigned c[D];
    longint unsigned acc;
    vec_t r;
    int e;
    r = '0;
    for (int k = 0; k < D; k++) c[k] = longint'(x[k*N +: N]) % Q;
    for (int o = 0; o < D; o++) begin
      acc = 0;
      for (int i = 0; i < D; i++) begin
        if (!iv) e = ((2 * brv(o) + 1) * i) % (2 * D);
        else     e = (2 * D - ((2 * brv(i) + 1) * o) % (2 * D)) % (2 * D);
        acc = (acc + c[i] * psi_pow[e]) % Q;
      end
      if (iv) acc = (acc * D_INV_TB) % Q;
      r[o*N +: N] = acc[N-1:0];
    end
    return r;
  endfunction

  task automatic check(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic service();
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      check(name_q[0], an, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(name_q.pop_front());
    end
  endtask

  // Drive one polynomial at the falling edge; its result is due LAT cycles later.
  task automatic cycle(input vec_t x, input logic iv, input vec_t ex, input string nm);
    @(negedge clk);
    cyc++;
    service();
    a   = x;
    inv = iv;
    exp_q.push_back(ex);
    due_q.push_back(cyc + LAT);
    name_q.push_back(nm);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (due_q.size() > 0 && guard < 2 * LAT) begin
      @(negedge clk);
      cyc++;
      service();
      a   = '0;
      inv = 1'b0;
      guard++;
    end
    if (due_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", due_q.size());
      exp_q.delete();
      due_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t delta0;
    vec_t delta1;
    vec_t ones;
    vec_t x;
    vec_t f;
    int unsigned r;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    inv      = 1'b0;
    a        = '0;

    psi_pow[0] = 1;
    for (int e = 1; e < 2 * D; e++) psi_pow[e] = (psi_pow[e-1] * 2) % Q;
    tf  = '0;
    itf = '0;
    for (int k = 0; k < D; k++) begin
      tf[k*N +: N]  = psi_pow[brv(k)][N-1:0];
      itf[k*N +: N] = psi_pow[(2 * D - brv(k)) % (2 * D)][N-1:0];
    end
    tf[N-1:0]  = 17'h1ABCD;
    itf[N-1:0] = 17'h0F0F0;

    // Reset held while clocking nonzero data: output stays cleared.
    #1 rst = 1'b0;
    a = fill(32'h1234);
    repeat (8) @(posedge clk);
    #1 check("reset_state", an, '0);
    @(negedge clk);
    a   = '0;
    rst = 1'b1;

    delta0 = '0;
    delta0[N-1:0] = 17'd1;
    delta1 = '0;
    delta1[2*N-1:N] = 17'd1;
    ones = fill(1);

    tbl[0] = '{a: '0,                inv: 1'b0, exp: '0};
    tbl[1] = '{a: delta0,            inv: 1'b0, exp: ones};
    tbl[2] = '{a: ones,              inv: 1'b1, exp: delta0};
    tbl[3] = '{a: fill(Q - 1),       inv: 1'b0, exp: model(fill(Q - 1), 1'b0)};
    tbl[4] = '{a: fill(Q - 1),       inv: 1'b1, exp: model(fill(Q - 1), 1'b1)};
    tbl[5] = '{a: fill(32'h1FFFF),   inv: 1'b0, exp: model(fill(32'h1FFFF - Q), 1'b0)};
    tbl[6] = '{a: fill(32'h1FFFF),   inv: 1'b1, exp: model(fill(32'h1FFFF - Q), 1'b1)};
    tbl[7] = '{a: delta1,            inv: 1'b0, exp: model(delta1, 1'b0)};

    for (int i = 0; i < 8; i++) cycle(tbl[i].a, tbl[i].inv, tbl[i].exp, $sformatf("tbl%0d", i));
    drain();

    // Mid-flight reset: output clears at once and nothing in flight resurfaces.
    for (int i = 0; i < LAT; i++) cycle(delta0, 1'b0, ones, "pre_reset");
    @(negedge clk);
    cyc++;
    service();
    #2 rst = 1'b0;
    #1 check("reset_async", an, '0);
    exp_q.delete();
    due_q.delete();
    name_q.delete();
    a   = '0;
    inv = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      cyc++;
      check("reset_flush", an, '0);
    end

    // Back-to-back alternating forward/inverse round trips with distinct vectors.
    for (int n = 0; n < 1000; n++) begin
      x = '0;
      for (int k = 0; k < D; k++) begin
        r = $urandom_range(Q - 1, 0);
        x[k*N +: N] = r[N-1:0];
      end
      f = model(x, 1'b0);
      cycle(x, 1'b0, f, "rt_forward");
      cycle(f, 1'b1, x, "rt_inverse");
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
